// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned LAT_W = 4;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Data has priority unless its streak has used up the fetch's patience.
    function automatic logic pick_grant(input logic if_req, input logic d_req,
                                        input logic streak_full);
        if (d_req && (!if_req || !streak_full)) begin
            return GNT_D;
        end
        return GNT_IF;
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter; expire_o is high while the count equals one.
module mem_lat_timer
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_d = expire_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            expire_d = (load_val_i == LAT_W'(1));
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d    = cnt_q - LAT_W'(1);
            expire_d = (cnt_q == LAT_W'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one fixed-latency access at a time, with a bounded fetch wait.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);

    arb_state_e          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                d_we_q, d_we_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;

    logic                tmr_load, tmr_dec, tmr_expire;
    logic                complete;

    mem_lat_timer u_lat_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (tmr_dec),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        d_we_d      = d_we_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    gnt_d    = pick_grant(if_req, d_req, streak_q == STREAK_MAX);
                    if (gnt_d == GNT_D) begin
                        d_we_d      = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // Streak only counts grants that actually made a fetch wait.
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        d_we_d     = 1'b0;
                        mem_addr_d = if_addr;
                        streak_d   = '0;
                    end
                end
            end
            ISSUE: begin
                tmr_load = 1'b1;
                if (MEM_LAT == 1) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_expire) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture read data and raise the granted ack on the edge into DONE.
        if (complete) begin
            if (gnt_q == GNT_IF) begin
                if_rdata_d = mem_rdata;
                if_ack_d   = 1'b1;
            end else begin
                d_ack_d = 1'b1;
                if (!d_we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            d_we_q      <= 1'b0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            d_we_q      <= d_we_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=2 main instance plus a
// MEM_LAT=1 instance for the short-latency corner.
module tb_mem_port_arbiter;

    localparam int unsigned LAT  = 2;
    localparam int unsigned MAXS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, mem_en, mem_we;

    logic        l1_if_req = 1'b0, l1_d_req = 1'b0, l1_d_we = 1'b0;
    logic [31:0] l1_if_addr = '0, l1_d_addr = '0, l1_d_wdata = '0;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ack, l1_d_ack, l1_mem_en, l1_mem_we;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C01_0004;
        return {a[15:0], ~a[15:0]};
    endfunction

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(MAXS)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    // Memory models: data is valid only in the cycle the arbiter must sample it.
    logic [3:0]  age = '0;
    logic [31:0] maddr = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            age   <= 4'd1;
            maddr <= mem_addr;
        end else if (age != 4'd0 && age != 4'd15) begin
            age <= age + 4'd1;
        end
    end
    assign mem_rdata    = (age == 4'(LAT - 1)) ? mem_fn(maddr) : 32'hBAD0_BAD0;
    assign l1_mem_rdata = l1_mem_en ? mem_fn(l1_mem_addr) : 32'hBAD0_BAD0;

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        acc_t a;
        int   ack_cyc;
    } pend_t;

    acc_t        exp_q[$];
    pend_t       ack_q[$];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    task automatic push_exp(input logic is_d, input logic we, input logic [31:0] a,
                            input logic [31:0] wd);
        acc_t e;
        e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        acc_t  e;
        pend_t p;
        if (rst) begin
            ack_q.delete();
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
        end else begin
            if (mem_en) begin
                check("mem_en_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    p.a = e;
                    p.ack_cyc = cyc + int'(LAT);
                    ack_q.push_back(p);
                end
            end
            if (if_ack || d_ack) begin
                check("ack_onehot", 64'(if_ack & d_ack), 64'd0);
                check("ack_expected", 64'(ack_q.size() != 0), 64'd1);
                if (ack_q.size() != 0) begin
                    p = ack_q.pop_front();
                    check("ack_src", 64'(d_ack), 64'(p.a.is_d));
                    check("ack_cycle", 64'(cyc), 64'(p.ack_cyc));
                    if (!p.a.is_d) exp_if_rdata = mem_fn(p.a.addr);
                    else if (!p.a.we) exp_d_rdata = mem_fn(p.a.addr);
                    check("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
                    check("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
                end
            end
        end
    end

    // Requester drivers: raise req now, hold until ack, drop it the cycle after.
    task automatic fetch(input logic [31:0] a, output int req_c, output int ack_c);
        if_req = 1'b1;
        if_addr = a;
        req_c = cyc;
        ack_c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_ack) begin
                ack_c = cyc;
                break;
            end
        end
        check("if_ack_timeout", 64'(ack_c >= 0), 64'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int req_c, output int ack_c);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        req_c = cyc;
        ack_c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d_ack) begin
                ack_c = cyc;
                break;
            end
        end
        check("d_ack_timeout", 64'(ack_c >= 0), 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({mem_en, mem_we, if_ack, d_ack}), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    endtask

    int t, a, t2, a2;
    int en1, en2, ak1, ak2;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Fetch only.
        push_exp(1'b0, 1'b0, 32'h40, 32'h0);
        fetch(32'h40, t, a);
        check("fetch_latency", 64'(a - t), 64'(LAT + 1));

        // Store, then a load that makes d_rdata non-zero.
        push_exp(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        data(1'b1, 32'h100, 32'hDEAD_BEEF, t, a);
        check("store_latency", 64'(a - t), 64'(LAT + 1));
        push_exp(1'b1, 1'b0, 32'h200, 32'h0);
        data(1'b0, 32'h200, 32'h0, t, a);

        // Both requesters held continuously: D, D, IF, D, D, IF.
        push_exp(1'b1, 1'b0, 32'h300, 32'h0);
        push_exp(1'b1, 1'b0, 32'h304, 32'h0);
        push_exp(1'b0, 1'b0, 32'h1000, 32'h0);
        push_exp(1'b1, 1'b1, 32'h308, 32'h5555_AAAA);
        push_exp(1'b1, 1'b0, 32'h30C, 32'h0);
        push_exp(1'b0, 1'b0, 32'h1004, 32'h0);
        fork
            begin
                fetch(32'h1000, t, a);
                fetch(32'h1004, t, a);
            end
            begin
                data(1'b0, 32'h300, 32'h0, t2, a2);
                data(1'b0, 32'h304, 32'h0, t2, a2);
                data(1'b1, 32'h308, 32'h5555_AAAA, t2, a2);
                data(1'b0, 32'h30C, 32'h0, t2, a2);
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("simul_all_granted", 64'(exp_q.size()), 64'd0);

        // Reset during WAIT of a load; the held request is served afterwards.
        push_exp(1'b1, 1'b0, 32'h500, 32'h0);
        push_exp(1'b1, 1'b0, 32'h500, 32'h0);
        fork
            data(1'b0, 32'h500, 32'h0, t, a);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (mem_en) break;
                end
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_outputs_zero("midreset");
            end
        join
        check("midreset_regrant_latency", 64'(a - t), 64'(LAT + 4));

        // MEM_LAT=1 corner on the second instance, back-to-back fetches.
        @(posedge clk); #1;
        l1_if_req = 1'b1;
        l1_if_addr = 32'h0;
        t = cyc;
        en1 = -1; en2 = -1; ak1 = -1; ak2 = -1;
        for (int i = 0; i < 30 && ak2 < 0; i++) begin
            @(negedge clk);
            if (l1_mem_en) begin
                if (en1 < 0) begin
                    en1 = cyc;
                end else begin
                    en2 = cyc;
                    check("l1_mem_addr2", 64'(l1_mem_addr), 64'h4);
                end
            end
            if (l1_if_ack) begin
                if (ak1 < 0) begin
                    ak1 = cyc;
                    check("l1_rdata1", 64'(l1_if_rdata), 64'(mem_fn(32'h0)));
                    l1_if_addr = 32'h4;
                end else begin
                    ak2 = cyc;
                    check("l1_rdata2", 64'(l1_if_rdata), 64'(mem_fn(32'h4)));
                end
            end
        end
        @(posedge clk); #1;
        l1_if_req = 1'b0;
        check("l1_en1_cycle", 64'(en1), 64'(t + 1));
        check("l1_ack1_cycle", 64'(ak1), 64'(t + 2));
        check("l1_en2_cycle", 64'(en2), 64'(t + 4));
        check("l1_ack2_cycle", 64'(ak2), 64'(t + 5));

        repeat (8) @(posedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("ack_q_drained", 64'(ack_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
